// File: rtl/mem_responder.sv
// Word-addressed unified instruction/data memory acting as the responder on the core memory port.
// One request at a time: accept on req, LATENCY wait cycles, then a one-cycle ready pulse with rdata/err.
module mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem [DEPTH_WORDS] = '{default: 32'd0};

   logic          cur_we;
   logic [3:0]    cur_be;
   logic [31:0]   cur_addr;
   logic [31:0]   cur_wdata;
   logic [31:0]   merged;
   logic [AW-1:0] widx;
   logic          cur_err;
   logic          enter_resp;
   logic          mem_wr;

   always_comb begin
      // With LATENCY=0 the RESP-entry edge is the acceptance edge, so it must see the live inputs.
      if (state_q == S_IDLE) begin
         cur_we    = we;
         cur_be    = be;
         cur_addr  = addr;
         cur_wdata = wdata;
      end else begin
         cur_we    = we_q;
         cur_be    = be_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
      end
      widx    = cur_addr[AW+1:2];
      cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(DEPTH_WORDS));
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = cur_be[i] ? cur_wdata[8*i +: 8] : mem[widx][8*i +: 8];
      end

      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      be_d       = be_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      enter_resp = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               we_d    = we;
               be_d    = be;
               addr_d  = addr;
               wdata_d = wdata;
               if (LATENCY == 0) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (enter_resp) begin
         err_d   = cur_err;
         rdata_d = (cur_err || cur_we) ? 32'd0 : mem[widx];
      end
      // Gated by rst_n so an edge seen while reset is held can never commit a write.
      mem_wr = enter_resp && cur_we && !cur_err && rst_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         be_q    <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem[widx] <= merged;
      end
   end

   assign rdata = rdata_q;
   assign err   = err_q;
   assign ready = (state_q == S_RESP);
   assign busy  = (state_q != S_IDLE);
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed unified instruction/data memory that acts as the responder on the multicycle core's memory port. The control unit/datapath is the initiator.
- Each request is accepted with a single-cycle strobe, held in a programmable wait-state pipeline, then completed with a one-cycle ready pulse carrying read data or an error flag.
- Lets the core stall fetch and load/store states on ready, so it does not depend on fixed single-cycle memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored. Power of two, at least 4.
- LATENCY, 2, wait cycles inserted between acceptance and response. 0 to 15 allowed.

Ports:
- clk  in  1  system clock; rising-edge active
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request strobe; sampled only in IDLE
- we  in  1  1 = write, 0 = read
- be  in  4  byte enables for writes; be[0] = bits 7:0
- addr  in  32  byte address
- wdata  in  32  write data
- rdata  out  32  registered read data; valid while ready=1
- ready  out  1  one-cycle completion pulse
- err  out  1  error flag; valid while ready=1
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state = IDLE; wait counter = 0.
  - rdata = 0, ready = 0, err = 0, busy = 0.
  - Memory array is not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On a clk edge with req=1, latch we, be, addr and wdata.
  - If LATENCY > 0: go to WAIT with counter = LATENCY-1.
  - If LATENCY = 0: go directly to RESP.
  - req=0: stay in IDLE.
- WAIT:
  - Counter decrements each cycle.
  - At counter = 0, the next edge enters RESP.
  - req, we, be, addr and wdata are ignored in WAIT. Requests are not queued.
- Entry into RESP:
  - Error check on the latched request: err = 1 if addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS.
  - Error case: rdata = 0 and no write occurs.
  - Read, no error: rdata = mem[addr[31:2]].
  - Write, no error: each byte lane with be[i]=1 is updated; rdata = 0; the memory write commits on this same edge.
  - be = 0 on a write is legal: no change to memory, err = 0.
- RESP:
  - ready = 1 for exactly one cycle, then the next edge returns to IDLE.
  - req is ignored in RESP. The earliest next acceptance is the cycle after RESP.
- Output holding and timing:
  - rdata and err hold their values after RESP until the next RESP.
  - ready is 0 in all states other than RESP.
  - busy = 1 in WAIT and RESP; it is a registered state decode.
  - Latency: an acceptance edge at cycle N gives ready high during cycle N+LATENCY+1.
  - Throughput: one transaction per LATENCY+2 cycles.
- Reset mid-operation:
  - Reset in WAIT aborts the transaction; no memory write takes place.
  - Reset during RESP: the write has already committed, and ready drops immediately.
- Read-after-write: a read of a word issued after that word's write RESP returns the new data.
- No X propagation: rdata must not go X on an error or on an unwritten-but-in-range read. Words that have never been written read as 0, since the array is initialised to 0 at elaboration.

Test Plan:
- LATENCY=2: read of addr 0x10 after a prior write of 0xDEADBEEF with be=4'hF. Required: ready is high exactly 3 cycles after the acceptance edge; rdata=0xDEADBEEF; err=0; busy is high for 3 cycles.
- Partial write: write 0x11223344 to 0x20 with be=4'b0101 over existing 0xAABBCCDD, then read 0x20. Required: rdata=0xAA22CC44.
- Errors:
  - Read at addr 0x02 gives err=1, rdata=0.
  - Write at addr 4*DEPTH_WORDS (0x400 at default) gives err=1, and a follow-up read of 0x0 is unchanged.
- Back-to-back plus ignored requests: hold req=1 continuously with incrementing reads. Required: ready pulses every 4 cycles; the addresses presented during WAIT and RESP are never serviced.
- LATENCY=0 build: a write then a read of 0x8 with wdata 0x0000CAFE. Required: each ready is high the cycle after acceptance; the read returns 0x0000CAFE.
- Async reset: assert rst_n=0 mid-clock while in WAIT of a write 0x12345678 to 0x30. Required: ready, busy and err fall to 0 without a clock edge; a later read of 0x30 returns the prior value.
